// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: datapath widths, opcode map
// (must agree with the ALU's parameters.vh) and the issue FSM state type.
package alu_issue_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OPCODE_SIZE = 4;
    localparam int REG_ADDR    = 3;
    localparam int IMM_WIDTH   = 8;

    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_ADDI = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] OP_ANDI = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] OP_OR   = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_XOR  = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OP_NOT  = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'd7;
    localparam logic [OPCODE_SIZE-1:0] OP_COMP = 4'd8;
    localparam logic [OPCODE_SIZE-1:0] OP_LT   = 4'd9;
    localparam logic [OPCODE_SIZE-1:0] OP_EQ   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } issue_state_t;

    // True for opcodes whose second operand comes from the immediate field.
    function automatic logic is_imm_op(input logic [OPCODE_SIZE-1:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI);
    endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file for the issue stage: two combinational operand read ports,
// one combinational debug read port, one synchronous write port.
// r0 reads as zero and ignores writes.
module issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int RA = REG_ADDR
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [RA-1:0]        i_rd_addr1,
    output logic [WORD_SIZE-1:0] o_rd_data1,
    input  logic [RA-1:0]        i_rd_addr2,
    output logic [WORD_SIZE-1:0] o_rd_data2,
    input  logic [RA-1:0]        i_dbg_addr,
    output logic [WORD_SIZE-1:0] o_dbg_data,
    input  logic                 i_wr_en,
    input  logic [RA-1:0]        i_wr_addr,
    input  logic [WORD_SIZE-1:0] i_wr_data
);

    localparam int NUM_REGS = 1 << RA;

    logic [WORD_SIZE-1:0] r_mem [NUM_REGS];

    // Synchronous clear of every entry; writes to r0 are dropped so it stays zero.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_mem[i_rd_addr1];
    assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : r_mem[i_rd_addr2];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback sequencer wrapped around a registered ALU.
// An instruction takes IDLE/CAPTURE -> ISSUE -> CAPTURE; the next one may be
// accepted during CAPTURE, giving one instruction every two cycles. A result
// still being written back is forwarded straight from the ALU output to any
// dependent operand accepted in the same cycle.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int RA = REG_ADDR,
    parameter int IW = IMM_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_instr_valid,
    output logic                   o_instr_ready,
    input  logic [OPCODE_SIZE-1:0] i_instr_opcode,
    input  logic [RA-1:0]          i_instr_rd,
    input  logic [RA-1:0]          i_instr_rs1,
    input  logic [RA-1:0]          i_instr_rs2,
    input  logic [IW-1:0]          i_instr_imm,
    output logic [OPCODE_SIZE-1:0] o_alu_opcode,
    output logic [WORD_SIZE-1:0]   o_alu_input1,
    output logic [WORD_SIZE-1:0]   o_alu_input2,
    output logic                   o_alu_enable,
    input  logic [WORD_SIZE-1:0]   i_alu_out,
    output logic                   o_wb_valid,
    output logic [RA-1:0]          o_wb_rd,
    output logic [WORD_SIZE-1:0]   o_wb_data,
    input  logic [RA-1:0]          i_dbg_addr,
    output logic [WORD_SIZE-1:0]   o_dbg_data
);

    issue_state_t           r_state;
    logic [OPCODE_SIZE-1:0] r_opcode;
    logic [WORD_SIZE-1:0]   r_input1;
    logic [WORD_SIZE-1:0]   r_input2;
    logic [RA-1:0]          r_rd;
    logic                   r_alu_enable;
    logic                   r_wb_valid;

    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_bypass_ok;
    logic [WORD_SIZE-1:0]   w_rf_data1;
    logic [WORD_SIZE-1:0]   w_rf_data2;
    logic [WORD_SIZE-1:0]   w_src1;
    logic [WORD_SIZE-1:0]   w_src2;
    logic [WORD_SIZE-1:0]   w_imm_sext;
    logic [WORD_SIZE-1:0]   w_imm_zext;
    logic [WORD_SIZE-1:0]   w_operand2;

    assign o_instr_ready = (r_state == ST_IDLE) || (r_state == ST_CAPTURE);
    assign w_accept      = i_instr_valid && o_instr_ready;

    // Writeback happens at the edge leaving CAPTURE; the regfile drops r0.
    assign w_wr_en = (r_state == ST_CAPTURE);

    issue_regfile #(
        .RA (RA)
    ) u_regfile (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_rd_addr1 (i_instr_rs1),
        .o_rd_data1 (w_rf_data1),
        .i_rd_addr2 (i_instr_rs2),
        .o_rd_data2 (w_rf_data2),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_rd),
        .i_wr_data  (i_alu_out)
    );

    // Immediate extension; the width-equal case needs no padding at all.
    if (WORD_SIZE > IW) begin : g_imm_ext
        assign w_imm_sext = {{(WORD_SIZE-IW){i_instr_imm[IW-1]}}, i_instr_imm};
        assign w_imm_zext = {{(WORD_SIZE-IW){1'b0}}, i_instr_imm};
    end else begin : g_imm_full
        assign w_imm_sext = i_instr_imm;
        assign w_imm_zext = i_instr_imm;
    end

    // The regfile write of the instruction in CAPTURE lands on the same edge
    // as this accept, so its value must come from the ALU output instead.
    assign w_bypass_ok = (r_state == ST_CAPTURE) && (r_rd != '0);
    assign w_src1 = (w_bypass_ok && (i_instr_rs1 == r_rd)) ? i_alu_out : w_rf_data1;
    assign w_src2 = (w_bypass_ok && (i_instr_rs2 == r_rd)) ? i_alu_out : w_rf_data2;

    // Second operand select: immediate forms override the rs2 read.
    always_comb begin
        w_operand2 = w_src2;
        if (is_imm_op(i_instr_opcode)) begin
            w_operand2 = (i_instr_opcode == OP_ADDI) ? w_imm_sext : w_imm_zext;
        end
    end

    // Issue FSM with registered ALU controls and writeback strobe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_opcode     <= '0;
            r_input1     <= '0;
            r_input2     <= '0;
            r_rd         <= '0;
            r_alu_enable <= 1'b0;
            r_wb_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wb_valid   <= 1'b0;
                    r_alu_enable <= w_accept;
                    if (w_accept) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_alu_enable <= 1'b0;
                    r_wb_valid   <= 1'b1;
                    r_state      <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_wb_valid   <= 1'b0;
                    r_alu_enable <= w_accept;
                    r_state      <= w_accept ? ST_ISSUE : ST_IDLE;
                end
                default: begin
                    r_wb_valid   <= 1'b0;
                    r_alu_enable <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
            // Operands and opcode hold their last values between instructions.
            if (w_accept) begin
                r_opcode <= i_instr_opcode;
                r_rd     <= i_instr_rd;
                r_input1 <= w_src1;
                r_input2 <= w_operand2;
            end
        end
    end

    assign o_alu_opcode = r_opcode;
    assign o_alu_input1 = r_input1;
    assign o_alu_input2 = r_input2;
    assign o_alu_enable = r_alu_enable;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_rd      = r_rd;
    assign o_wb_data    = i_alu_out;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural registered ALU attached.
// The reference model executes each instruction in program order on a plain
// register array at the moment it is accepted.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_opcode;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs1;
    logic [2:0]  instr_rs2;
    logic [7:0]  instr_imm;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic        alu_enable;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_regs [8];

    alu_issue_stage dut (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_instr_valid  (instr_valid),
        .o_instr_ready  (instr_ready),
        .i_instr_opcode (instr_opcode),
        .i_instr_rd     (instr_rd),
        .i_instr_rs1    (instr_rs1),
        .i_instr_rs2    (instr_rs2),
        .i_instr_imm    (instr_imm),
        .o_alu_opcode   (alu_opcode),
        .o_alu_input1   (alu_input1),
        .o_alu_input2   (alu_input2),
        .o_alu_enable   (alu_enable),
        .i_alu_out      (alu_out),
        .o_wb_valid     (wb_valid),
        .o_wb_rd        (wb_rd),
        .o_wb_data      (wb_data),
        .i_dbg_addr     (dbg_addr),
        .o_dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            OP_ADD, OP_ADDI: return a + b;
            OP_AND, OP_ANDI: return a & b;
            OP_OR:           return a | b;
            OP_XOR:          return a ^ b;
            OP_NOT:          return ~a;
            OP_SUB:          return a - b;
            OP_COMP:         return (a > b) ? 16'd1 : 16'd0;
            OP_LT:           return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            OP_EQ:           return (a == b) ? 16'd1 : 16'd0;
            default:         return 16'd0;
        endcase
    endfunction

    // Registered ALU: result appears the cycle after alu_enable.
    always @(posedge clk) begin
        if (reset) alu_out <= 16'd0;
        else if (alu_enable) alu_out <= alu_f(alu_opcode, alu_input1, alu_input2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the CAPTURE-cycle negedge, so a
    // following call issues back-to-back.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] imm);
        logic [15:0] a, b, res;
        int n;
        a = ref_regs[rs1];
        if (op == OP_ADDI)      b = {{8{imm[7]}}, imm};
        else if (op == OP_ANDI) b = {8'h00, imm};
        else                    b = ref_regs[rs2];
        res = alu_f(op, a, b);
        if (rd != 3'd0) ref_regs[rd] = res;
        instr_opcode = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("issue_enable", {31'd0, alu_enable}, 32'd1);
        check("issue_ready", {31'd0, instr_ready}, 32'd0);
        check("issue_opcode", {28'd0, alu_opcode}, {28'd0, op});
        check("issue_in1", {16'd0, alu_input1}, {16'd0, a});
        check("issue_in2", {16'd0, alu_input2}, {16'd0, b});
        check("issue_wb_valid", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        check("cap_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("cap_wb_rd", {29'd0, wb_rd}, {29'd0, rd});
        check("cap_wb_data", {16'd0, wb_data}, {16'd0, res});
        check("cap_enable", {31'd0, alu_enable}, 32'd0);
        check("cap_ready", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
            check("idle_enable", {31'd0, alu_enable}, 32'd0);
            check("idle_ready", {31'd0, instr_ready}, 32'd1);
        end
    endtask

    task automatic dbg(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        check(tag, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        reset = 1'b1; instr_valid = 1'b0; instr_opcode = 4'd0; instr_rd = 3'd0;
        instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 8'd0; dbg_addr = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_enable", {31'd0, alu_enable}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_in1", {16'd0, alu_input1}, 32'd0);
        check("rst_in2", {16'd0, alu_input2}, 32'd0);
        for (int i = 0; i < 8; i++) dbg(3'(i), 16'h0000, "rst_dbg");

        // 1: ADDI r1,r0,5
        @(negedge clk);
        issue(OP_ADDI, 3'd1, 3'd0, 3'd0, 8'h05);
        idle(2);
        dbg(3'd1, 16'h0005, "t1_r1");

        // 2: sign and zero extension
        issue(OP_ADDI, 3'd2, 3'd0, 3'd0, 8'hFF);
        issue(OP_ANDI, 3'd3, 3'd2, 3'd0, 8'hFF);
        idle(1);
        dbg(3'd2, 16'hFFFF, "t2_r2_sext");
        dbg(3'd3, 16'h00FF, "t2_r3_zext");

        // 3: back-to-back dependent pair through the bypass
        issue(OP_ADDI, 3'd1, 3'd0, 3'd0, 8'h03);
        issue(OP_ADD, 3'd4, 3'd1, 3'd1, 8'h00);
        idle(1);
        dbg(3'd4, 16'h0006, "t3_r4_bypass");

        // 4: r0 write dropped, no bypass from r0
        issue(OP_ADDI, 3'd0, 3'd0, 3'd0, 8'h07);
        issue(OP_ADD, 3'd5, 3'd0, 3'd0, 8'h00);
        idle(1);
        dbg(3'd0, 16'h0000, "t4_r0");
        dbg(3'd5, 16'h0000, "t4_r5");

        // 5: r1=00F0, r2=0F0F, then XOR and NOT
        issue(OP_ADDI, 3'd1, 3'd0, 3'd0, 8'hF0);
        issue(OP_ANDI, 3'd1, 3'd1, 3'd0, 8'hFF);
        issue(OP_ADDI, 3'd2, 3'd0, 3'd0, 8'h0F);
        issue(OP_ADDI, 3'd3, 3'd0, 3'd0, 8'h0F);
        for (int i = 0; i < 8; i++) issue(OP_ADD, 3'd3, 3'd3, 3'd3, 8'h00);
        issue(OP_OR, 3'd2, 3'd2, 3'd3, 8'h00);
        issue(OP_XOR, 3'd6, 3'd1, 3'd2, 8'h00);
        issue(OP_NOT, 3'd7, 3'd1, 3'd0, 8'h00);
        idle(1);
        dbg(3'd1, 16'h00F0, "t5_r1");
        dbg(3'd2, 16'h0F0F, "t5_r2");
        dbg(3'd6, 16'h0FFF, "t5_r6_xor");
        dbg(3'd7, 16'hFF0F, "t5_r7_not");

        // Random instruction stream, including unknown opcodes and gaps
        for (int k = 0; k < 40; k++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);
        for (int i = 0; i < 8; i++) dbg(3'(i), ref_regs[i], "rand_regfile");

        // 6: reset during ISSUE aborts the instruction
        instr_opcode = OP_ADDI; instr_rd = 3'd1; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
        instr_imm = 8'h09; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("t6_in_issue", {31'd0, alu_enable}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        @(negedge clk);
        check("t6_ready_after_rst", {31'd0, instr_ready}, 32'd1);
        check("t6_no_wb", {31'd0, wb_valid}, 32'd0);
        check("t6_enable", {31'd0, alu_enable}, 32'd0);
        check("t6_opcode", {28'd0, alu_opcode}, 32'd0);
        idle(2);
        dbg(3'd1, 16'h0000, "t6_r1");

        // Stage still works after the abort
        issue(OP_ADDI, 3'd1, 3'd0, 3'd0, 8'h09);
        idle(1);
        dbg(3'd1, 16'h0009, "t6_r1_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
